// File: rtl/low_freq_fir.sv
// FIR reader for the low-frequency sample queue: one MAC run per queue read-out burst.
// Issues coefficient addresses, accumulates stereo products and emits one saturated result pair.
module low_freq_fir #(
  parameter int unsigned NUM_TAPS = 1021,
  parameter int unsigned AW       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sequencing,
  input  logic signed [15:0]   smpl_lft,
  input  logic signed [15:0]   smpl_rght,
  input  logic signed [15:0]   coeff,
  output logic        [AW-1:0] coeff_addr,
  output logic signed [15:0]   lft_out,
  output logic signed [15:0]   rght_out,
  output logic                 valid,
  output logic                 seq_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, HOLD} state_e;

  state_e                 state_q;
  logic [AW-1:0]          addr_q;
  logic                   start_c, issue_c, last_c;
  logic                   tv_q, tv_last_q, pv_q, pv_last_q;
  logic signed [PW-1:0]   sl_x, sr_x, c_x;
  logic signed [PW-1:0]   prod_l_q, prod_r_q;
  logic signed [PW-1:0]   acc_l_q, acc_r_q, acc_l_d, acc_r_d;

  // Q1.15 saturation of a 32-bit accumulator down to 16 bits
  function automatic logic signed [DW-1:0] sat16(input logic signed [PW-1:0] a);
    logic signed [DW-1:0] r;
    case (a[31:30])
      2'b01:   r = 16'sh7FFF;
      2'b10:   r = 16'sh8000;
      default: r = a[30:15];
    endcase
    return r;
  endfunction

  assign start_c    = (state_q == IDLE) && sequencing;
  assign issue_c    = sequencing && ((state_q == IDLE) || (state_q == MAC));
  assign last_c     = issue_c && (addr_q == LAST_ADDR);
  assign coeff_addr = addr_q;

  assign sl_x = PW'(smpl_lft);
  assign sr_x = PW'(smpl_rght);
  assign c_x  = PW'(coeff);

  // A run start clears the accumulators; stale products from an aborted run are dropped
  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (start_c) begin
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (pv_q) begin
      acc_l_d = acc_l_q + prod_l_q;
      acc_r_d = acc_r_q + prod_r_q;
    end
  end

  // Term-valid tags travel with each issued term through multiply and accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q      <= 1'b0;
      tv_last_q <= 1'b0;
      pv_q      <= 1'b0;
      pv_last_q <= 1'b0;
      prod_l_q  <= '0;
      prod_r_q  <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
    end else begin
      tv_q      <= issue_c;
      tv_last_q <= last_c;
      pv_q      <= tv_q;
      pv_last_q <= tv_last_q;
      if (tv_q) begin
        prod_l_q <= sl_x * c_x;
        prod_r_q <= sr_x * c_x;
      end
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
    end
  end

  // Run control: address issue, abort detection, result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      lft_out  <= '0;
      rght_out <= '0;
      valid    <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      seq_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sequencing) begin
            state_q <= last_c ? DRAIN : MAC;
            addr_q  <= last_c ? '0 : AW'(1);
          end
        end
        MAC: begin
          if (!sequencing) begin
            seq_err <= 1'b1;
            addr_q  <= '0;
            state_q <= IDLE;
          end else if (last_c) begin
            addr_q  <= '0;
            state_q <= DRAIN;
          end else begin
            addr_q  <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (pv_last_q) begin
            lft_out  <= sat16(acc_l_d);
            rght_out <= sat16(acc_r_d);
            valid    <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (!sequencing) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
